// File: rtl/hb_decimate_pkg.sv
// Shared widths, coefficient set and FSM encoding for the 2:1 half-band decimator.
package hb_decimate_pkg;

    localparam int DATA_WIDTH_DEF = 16;
    localparam int COEF_WIDTH_DEF = 18;
    localparam int NCOEF_DEF      = 4;

    typedef logic signed [COEF_WIDTH_DEF-1:0] coef_t;

    // Pair coefficients, outermost first, Q1.17; twice their sum is 0.5, giving unity DC gain with the centre tap.
    localparam coef_t HB_COEF [NCOEF_DEF] = '{
        -18'sd768, 18'sd2816, -18'sd7680, 18'sd38400
    };

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MAC  = 2'd1,
        ST_OUT  = 2'd2
    } hb_state_e;

    function automatic int acc_width(input int dw, input int cw, input int nc);
        return dw + cw + 1 + $clog2(nc + 1);
    endfunction

endpackage

// File: rtl/hb_mac.sv
// Pre-add / multiply / accumulate slice; one coefficient pair per enabled cycle.
module hb_mac
    import hb_decimate_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int COEF_WIDTH = COEF_WIDTH_DEF,
    parameter int ACC_WIDTH  = acc_width(DATA_WIDTH_DEF, COEF_WIDTH_DEF, NCOEF_DEF)
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         clr,
    input  logic                         en,
    input  logic signed [DATA_WIDTH-1:0] tap_a,
    input  logic signed [DATA_WIDTH-1:0] tap_b,
    input  logic signed [COEF_WIDTH-1:0] coef,
    output logic signed [ACC_WIDTH-1:0]  acc_sum
);

    localparam int PRE_WIDTH  = DATA_WIDTH + 1;
    localparam int PROD_WIDTH = PRE_WIDTH + COEF_WIDTH;

    logic signed [PRE_WIDTH-1:0]  preadd_r;
    logic signed [COEF_WIDTH-1:0] coef_r;
    logic                         valid_r;
    logic signed [ACC_WIDTH-1:0]  acc_r;
    logic signed [PRE_WIDTH-1:0]  preadd_s;
    logic signed [PROD_WIDTH-1:0] pre_ext_s;
    logic signed [PROD_WIDTH-1:0] coef_ext_s;
    logic signed [PROD_WIDTH-1:0] prod_s;

    // Pre-add, full-width product and the accumulator's next value (product folded in when valid).
    always_comb begin
        preadd_s   = {tap_a[DATA_WIDTH-1], tap_a} + {tap_b[DATA_WIDTH-1], tap_b};
        pre_ext_s  = {{(PROD_WIDTH-PRE_WIDTH){preadd_r[PRE_WIDTH-1]}}, preadd_r};
        coef_ext_s = {{(PROD_WIDTH-COEF_WIDTH){coef_r[COEF_WIDTH-1]}}, coef_r};
        prod_s     = pre_ext_s * coef_ext_s;
        if (valid_r) begin
            acc_sum = acc_r + {{(ACC_WIDTH-PROD_WIDTH){prod_s[PROD_WIDTH-1]}}, prod_s};
        end else begin
            acc_sum = acc_r;
        end
    end

    // Operand pipeline and accumulator; clr empties both.
    always_ff @(posedge clk) begin
        if (!reset) begin
            preadd_r <= {PRE_WIDTH{1'b0}};
            coef_r   <= {COEF_WIDTH{1'b0}};
            valid_r  <= 1'b0;
            acc_r    <= {ACC_WIDTH{1'b0}};
        end else if (clr) begin
            preadd_r <= {PRE_WIDTH{1'b0}};
            coef_r   <= {COEF_WIDTH{1'b0}};
            valid_r  <= 1'b0;
            acc_r    <= {ACC_WIDTH{1'b0}};
        end else begin
            valid_r <= en;
            acc_r   <= acc_sum;
            if (en) begin
                preadd_r <= preadd_s;
                coef_r   <= coef;
            end
        end
    end

endmodule

// File: rtl/hb_decimate.sv
// 2:1 half-band decimator: tap line, pair phase, MAC sequencing, round/saturate and output strobes.
module hb_decimate
    import hb_decimate_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int COEF_WIDTH = COEF_WIDTH_DEF,
    parameter int NCOEF      = NCOEF_DEF
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         rate_stb,
    input  logic                         bypass,
    input  logic                         strobe_in,
    input  logic                         last_in,
    input  logic signed [DATA_WIDTH-1:0] signal_in,
    output logic                         strobe_out,
    output logic                         last_out,
    output logic signed [DATA_WIDTH-1:0] signal_out,
    output logic                         overrun
);

    localparam int NTAPS     = 4 * NCOEF - 1;
    localparam int CENTER    = 2 * NCOEF - 1;
    localparam int ACC_WIDTH = acc_width(DATA_WIDTH, COEF_WIDTH, NCOEF);
    localparam int K_WIDTH   = (NCOEF > 1) ? $clog2(NCOEF) : 1;
    localparam int IDX_WIDTH = $clog2(NTAPS);

    localparam logic [K_WIDTH-1:0]        K_ZERO = {K_WIDTH{1'b0}};
    localparam logic [K_WIDTH-1:0]        K_ONE  = K_WIDTH'(1);
    localparam logic [K_WIDTH-1:0]        K_LAST = K_WIDTH'(NCOEF - 1);
    localparam logic [IDX_WIDTH-1:0]      IDX_TOP = IDX_WIDTH'(NTAPS - 1);
    localparam logic signed [ACC_WIDTH-1:0] RND =
        {{(ACC_WIDTH-COEF_WIDTH+1){1'b0}}, 1'b1, {(COEF_WIDTH-2){1'b0}}};

    logic signed [DATA_WIDTH-1:0] taps_r [NTAPS];
    hb_state_e                    state_r;
    hb_state_e                    state_s;
    logic [K_WIDTH-1:0]           k_r;
    logic [K_WIDTH-1:0]           k_s;
    logic                         phase_r;
    logic                         last_pend_r;
    logic                         overrun_r;
    logic                         strobe_out_r;
    logic                         last_out_r;
    logic signed [DATA_WIDTH-1:0] signal_out_r;

    logic                         busy_s;
    logic                         accept_s;
    logic                         trigger_s;
    logic                         drop_s;
    logic                         mac_clr_s;
    logic                         mac_en_s;
    logic [IDX_WIDTH-1:0]         idx_a_s;
    logic [IDX_WIDTH-1:0]         idx_b_s;
    logic signed [DATA_WIDTH-1:0] tap_a_s;
    logic signed [DATA_WIDTH-1:0] tap_b_s;
    logic signed [COEF_WIDTH-1:0] coef_s;
    logic signed [ACC_WIDTH-1:0]  acc_sum_s;
    logic signed [ACC_WIDTH-1:0]  center_s;
    logic signed [ACC_WIDTH-1:0]  final_s;
    logic signed [ACC_WIDTH-1:0]  shifted_s;
    logic signed [DATA_WIDTH-1:0] sat_s;

    function automatic logic signed [DATA_WIDTH-1:0] sat_data(input logic signed [ACC_WIDTH-1:0] v);
        logic fits;
        fits = (&v[ACC_WIDTH-1:DATA_WIDTH-1]) | ~(|v[ACC_WIDTH-1:DATA_WIDTH-1]);
        if (fits) begin
            return v[DATA_WIDTH-1:0];
        end else if (v[ACC_WIDTH-1]) begin
            return {1'b1, {(DATA_WIDTH-1){1'b0}}};
        end else begin
            return {1'b0, {(DATA_WIDTH-1){1'b1}}};
        end
    endfunction

    // Input qualification: rate_stb wins over strobe_in, bypass freezes the tap line.
    always_comb begin
        busy_s    = (state_r != ST_IDLE);
        accept_s  = strobe_in & ~busy_s & ~bypass & ~rate_stb;
        trigger_s = accept_s & (phase_r | last_in);
        drop_s    = strobe_in & busy_s & ~bypass & ~rate_stb;
        mac_clr_s = (state_r == ST_IDLE) | rate_stb;
    end

    // Next-state logic: one MAC cycle per coefficient pair, then a single output cycle.
    always_comb begin
        state_s  = state_r;
        k_s      = k_r;
        mac_en_s = 1'b0;
        if (rate_stb) begin
            state_s = ST_IDLE;
            k_s     = K_ZERO;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    k_s = K_ZERO;
                    if (trigger_s) begin
                        state_s = ST_MAC;
                    end else begin
                        state_s = ST_IDLE;
                    end
                end
                ST_MAC: begin
                    mac_en_s = 1'b1;
                    if (k_r == K_LAST) begin
                        state_s = ST_OUT;
                        k_s     = K_ZERO;
                    end else begin
                        k_s = k_r + K_ONE;
                    end
                end
                ST_OUT: begin
                    state_s = ST_IDLE;
                end
                default: begin
                    state_s = ST_IDLE;
                    k_s     = K_ZERO;
                end
            endcase
        end
    end

    // Symmetric tap pair for step k, centre term, rounding and saturation.
    always_comb begin
        idx_a_s   = IDX_WIDTH'({k_r, 1'b0});
        idx_b_s   = IDX_TOP - idx_a_s;
        tap_a_s   = taps_r[idx_a_s];
        tap_b_s   = taps_r[idx_b_s];
        coef_s    = HB_COEF[k_r];
        center_s  = {{(ACC_WIDTH-DATA_WIDTH){taps_r[CENTER][DATA_WIDTH-1]}}, taps_r[CENTER]} <<< (COEF_WIDTH-2);
        final_s   = acc_sum_s + center_s + RND;
        shifted_s = final_s >>> (COEF_WIDTH-1);
        sat_s     = sat_data(shifted_s);
    end

    hb_mac #(
        .DATA_WIDTH (DATA_WIDTH),
        .COEF_WIDTH (COEF_WIDTH),
        .ACC_WIDTH  (ACC_WIDTH)
    ) u_mac (
        .clk     (clk),
        .reset   (reset),
        .clr     (mac_clr_s),
        .en      (mac_en_s),
        .tap_a   (tap_a_s),
        .tap_b   (tap_b_s),
        .coef    (coef_s),
        .acc_sum (acc_sum_s)
    );

    // Tap line: newest sample at index 0, shifted only on accepted strobes.
    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int i = 0; i < NTAPS; i++) begin
                taps_r[i] <= {DATA_WIDTH{1'b0}};
            end
        end else if (accept_s) begin
            taps_r[0] <= signal_in;
            for (int i = 1; i < NTAPS; i++) begin
                taps_r[i] <= taps_r[i-1];
            end
        end
    end

    // FSM, pair phase, pending last flag and sticky overrun.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_r     <= ST_IDLE;
            k_r         <= K_ZERO;
            phase_r     <= 1'b0;
            last_pend_r <= 1'b0;
            overrun_r   <= 1'b0;
        end else begin
            state_r <= state_s;
            k_r     <= k_s;
            if (rate_stb) begin
                phase_r     <= 1'b0;
                last_pend_r <= 1'b0;
                overrun_r   <= 1'b0;
            end else begin
                if (accept_s) begin
                    phase_r <= ~phase_r & ~last_in;
                end
                if (trigger_s) begin
                    last_pend_r <= last_in;
                end
                if (drop_s) begin
                    overrun_r <= 1'b1;
                end
            end
        end
    end

    // Output register: pass-through in bypass, otherwise one strobe per completed MAC.
    always_ff @(posedge clk) begin
        if (!reset) begin
            strobe_out_r <= 1'b0;
            last_out_r   <= 1'b0;
            signal_out_r <= {DATA_WIDTH{1'b0}};
        end else if (bypass) begin
            strobe_out_r <= strobe_in;
            last_out_r   <= last_in;
            signal_out_r <= signal_in;
        end else if ((state_r == ST_OUT) && !rate_stb) begin
            strobe_out_r <= 1'b1;
            last_out_r   <= last_pend_r;
            signal_out_r <= sat_s;
        end else begin
            strobe_out_r <= 1'b0;
            last_out_r   <= 1'b0;
        end
    end

    assign strobe_out = strobe_out_r;
    assign last_out   = last_out_r;
    assign signal_out = signal_out_r;
    assign overrun    = overrun_r;

endmodule

// File: tb/tb_hb_decimate.sv
// Directed bench for hb_decimate: impulse, DC, saturation, overrun, forced output, reset and bypass.
module tb_hb_decimate;

    localparam int LAT  = 6;
    localparam int NONE = 99999;

    logic               clk = 1'b0;
    logic               reset;
    logic               rate_stb;
    logic               bypass;
    logic               strobe_in;
    logic               last_in;
    logic signed [15:0] signal_in;
    logic               strobe_out;
    logic               last_out;
    logic signed [15:0] signal_out;
    logic               overrun;

    int n_cmp = 0;
    int n_err = 0;
    int cyc   = 0;
    int in_cyc = 0;
    int trig_cyc = 0;
    int oq[$];
    int lq[$];
    int cq[$];
    int imp_exp[8] = '{-96, 352, -960, 4800, 4800, -960, 352, -96};
    int ctr_exp[4] = '{0, 0, 0, 8192};

    hb_decimate dut (
        .clk        (clk),
        .reset      (reset),
        .rate_stb   (rate_stb),
        .bypass     (bypass),
        .strobe_in  (strobe_in),
        .last_in    (last_in),
        .signal_in  (signal_in),
        .strobe_out (strobe_out),
        .last_out   (last_out),
        .signal_out (signal_out),
        .overrun    (overrun)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (strobe_out === 1'b1) begin
            oq.push_back(int'(signal_out));
            lq.push_back(int'(last_out));
            cq.push_back(cyc);
        end
    end

    task automatic check_val(input string tag, input longint obs, input longint exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input int val, input logic last, input int gap);
        signal_in = 16'(val);
        strobe_in = 1'b1;
        last_in   = last;
        in_cyc    = cyc;
        tick();
        strobe_in = 1'b0;
        last_in   = 1'b0;
        signal_in = 16'sd0;
        repeat (gap - 1) tick();
    endtask

    task automatic clear_q();
        oq.delete();
        lq.delete();
        cq.delete();
    endtask

    task automatic flush();
        for (int i = 0; i < 16; i++) send(0, 1'b0, 10);
        clear_q();
    endtask

    function automatic int o_at(input int i);
        return (i < oq.size()) ? oq[i] : NONE;
    endfunction

    function automatic int l_at(input int i);
        return (i < lq.size()) ? lq[i] : NONE;
    endfunction

    function automatic int c_at(input int i);
        return (i < cq.size()) ? cq[i] : NONE;
    endfunction

    // Tap pattern that drives every coefficient product the same sign.
    function automatic int sat_val(input int idx, input bit neg);
        int s;
        case (idx)
            0, 4, 10, 14:    s = -1;
            2, 6, 7, 8, 12:  s = 1;
            default:         s = 0;
        endcase
        if (neg) s = -s;
        return (s > 0) ? 32767 : ((s < 0) ? -32768 : 0);
    endfunction

    initial begin
        reset = 1'b0; rate_stb = 1'b0; bypass = 1'b0;
        strobe_in = 1'b0; last_in = 1'b0; signal_in = 16'sd0;
        repeat (3) tick();
        check_val("rst_strobe_out", strobe_out, 0);
        check_val("rst_last_out", last_out, 0);
        check_val("rst_signal_out", signal_out, 0);
        check_val("rst_overrun", overrun, 0);
        reset = 1'b1;
        tick();

        // impulse on second sample of a pair walks through the pair coefficients
        clear_q();
        for (int i = 0; i < 16; i++) begin
            send((i == 1) ? 16384 : 0, 1'b0, 32);
            if (i == 1) trig_cyc = in_cyc;
        end
        check_val("imp_count", oq.size(), 8);
        for (int i = 0; i < 8; i++) check_val($sformatf("imp_out%0d", i), o_at(i), imp_exp[i]);
        check_val("imp_latency", c_at(0) - trig_cyc, LAT);
        check_val("imp_last", l_at(0), 0);

        // impulse on first sample of a pair only meets the centre tap
        clear_q();
        for (int i = 0; i < 8; i++) send((i == 0) ? 16384 : 0, 1'b0, 32);
        check_val("ctr_count", oq.size(), 4);
        for (int i = 0; i < 4; i++) check_val($sformatf("ctr_out%0d", i), o_at(i), ctr_exp[i]);
        flush();

        // DC gain
        for (int i = 0; i < 200; i++) send(1000, 1'b0, 32);
        check_val("dc_count", oq.size(), 100);
        for (int i = 7; i < 100; i++) check_val($sformatf("dc_out%0d", i), o_at(i), 1000);

        // saturation both ways
        clear_q();
        for (int j = 0; j < 16; j++) send(sat_val(15 - j, 1'b0), 1'b0, 12);
        check_val("sat_pos_count", oq.size(), 8);
        check_val("sat_pos", o_at(7), 32767);
        clear_q();
        for (int j = 0; j < 16; j++) send(sat_val(15 - j, 1'b1), 1'b0, 12);
        check_val("sat_neg", o_at(7), -32768);
        flush();

        // overrun: two strobes land during MAC/OUT and must vanish
        send(0, 1'b0, 10);
        send(16384, 1'b0, 2);
        trig_cyc = in_cyc;
        send(20000, 1'b0, 2);
        send(-5000, 1'b0, 30);
        check_val("ovr_set", overrun, 1);
        send(0, 1'b0, 32);
        send(0, 1'b0, 32);
        check_val("ovr_count", oq.size(), 2);
        check_val("ovr_out0", o_at(0), -96);
        check_val("ovr_latency", c_at(0) - trig_cyc, LAT);
        check_val("ovr_out1", o_at(1), 352);
        check_val("ovr_sticky", overrun, 1);
        rate_stb = 1'b1;
        tick();
        rate_stb = 1'b0;
        check_val("ovr_cleared", overrun, 0);

        // last_in on first sample forces an output
        flush();
        send(16384, 1'b1, 32);
        trig_cyc = in_cyc;
        check_val("last_count", oq.size(), 1);
        check_val("last_out_val", o_at(0), -96);
        check_val("last_flag", l_at(0), 1);
        check_val("last_latency", c_at(0) - trig_cyc, LAT);
        send(0, 1'b0, 32);
        check_val("last_phase0", oq.size(), 1);
        send(0, 1'b0, 32);
        check_val("last_next_count", oq.size(), 2);
        check_val("last_next_val", o_at(1), 352);
        check_val("last_next_flag", l_at(1), 0);

        // reset pulse mid-MAC aborts and clears everything
        flush();
        send(0, 1'b0, 10);
        send(16384, 1'b0, 2);
        send(777, 1'b0, 1);
        check_val("rmid_ovr", overrun, 1);
        reset = 1'b0;
        tick();
        reset = 1'b1;
        repeat (20) tick();
        check_val("rmid_no_out", oq.size(), 0);
        check_val("rmid_strobe", strobe_out, 0);
        check_val("rmid_signal", signal_out, 0);
        check_val("rmid_last", last_out, 0);
        check_val("rmid_overrun", overrun, 0);
        send(0, 1'b0, 10);
        send(0, 1'b0, 20);
        check_val("rmid_taps_count", oq.size(), 1);
        check_val("rmid_taps_clear", o_at(0), 0);

        // bypass pass-through
        bypass = 1'b1;
        rate_stb = 1'b1;
        tick();
        rate_stb = 1'b0;
        clear_q();
        send(1234, 1'b1, 4);
        check_val("byp_count", oq.size(), 1);
        check_val("byp_val", o_at(0), 1234);
        check_val("byp_last", l_at(0), 1);
        check_val("byp_latency", c_at(0) - in_cyc, 1);
        bypass = 1'b0;
        rate_stb = 1'b1;
        tick();
        rate_stb = 1'b0;
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
